// File: rtl/timer_alert_if.sv
// Signal bundle between the elapsed-time counter/user controls and the alert block.
interface timer_alert_if;
    logic       start;
    logic [3:0] one_digits;
    logic [3:0] ten_digits;
    logic       done;
    logic       ack;
    logic       warn_led;
    logic       buzzer;
    logic       alarm_active;
    logic [2:0] burst_cnt;
    logic       bcd_err;

    // Driver side: upstream counter and user controls.
    modport master (
        output start, one_digits, ten_digits, done, ack,
        input  warn_led, buzzer, alarm_active, burst_cnt, bcd_err
    );

    // Alert block side.
    modport slave (
        input  start, one_digits, ten_digits, done, ack,
        output warn_led, buzzer, alarm_active, burst_cnt, bcd_err
    );
endinterface

// File: rtl/timer_alert.sv
// Timer alert: warning LED near the end of the countdown, then a burst/pause buzzer
// alarm that auto-silences after MAX_BURSTS bursts or on user acknowledge.
module timer_alert #(
    parameter int unsigned WARN_AT    = 40,
    parameter int unsigned BURST_LEN  = 6,
    parameter int unsigned MAX_BURSTS = 3
) (
    input  logic         OSClk,
    input  logic         reset,
    timer_alert_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StWarn,
        StAlarm,
        StPause,
        StSilent
    } state_e;

    localparam int unsigned      PhaseW    = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(BURST_LEN - 1);
    localparam logic [2:0]        MaxBursts = 3'(MAX_BURSTS);
    localparam logic [6:0]        WarnAt    = 7'(WARN_AT);

    state_e            state_q, state_d;
    logic [PhaseW-1:0] phase_q, phase_d;
    logic              warn_led_q, warn_led_d;
    logic              buzzer_q, buzzer_d;
    logic              alarm_active_q, alarm_active_d;
    logic [2:0]        burst_cnt_q, burst_cnt_d;
    logic              bcd_err_q, bcd_err_d;

    logic       digit_bad;
    logic [6:0] elapsed;
    logic       at_warn;

    // Elapsed seconds from the BCD digits; a malformed digit suppresses the threshold test.
    always_comb begin
        digit_bad = (bus.one_digits > 4'd9) || (bus.ten_digits > 4'd9);
        elapsed   = 7'(bus.ten_digits) * 7'd10 + 7'(bus.one_digits);
        at_warn   = !digit_bad && (elapsed >= WarnAt);
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        buzzer_d    = buzzer_q;
        burst_cnt_d = burst_cnt_q;
        bcd_err_d   = bcd_err_q | digit_bad;

        case (state_q)
            StIdle: begin
                if (bus.done) begin
                    state_d = StAlarm;
                end else if (bus.start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // done wins over the warning threshold so a late warning never flashes
                if (bus.done) begin
                    state_d = StAlarm;
                end else if (!bus.start) begin
                    state_d = StIdle;
                end else if (at_warn) begin
                    state_d = StWarn;
                end
            end
            StWarn: begin
                if (bus.done) begin
                    state_d = StAlarm;
                end else if (!bus.start) begin
                    state_d = StIdle;
                end
            end
            StAlarm: begin
                if (bus.ack) begin
                    state_d = StSilent;
                end else if (phase_q == PhaseLast) begin
                    state_d = StPause;
                    phase_d = '0;
                end else begin
                    phase_d  = phase_q + PhaseW'(1);
                    buzzer_d = ~buzzer_q;
                end
            end
            StPause: begin
                if (bus.ack) begin
                    state_d = StSilent;
                end else if (phase_q == PhaseLast) begin
                    state_d = (burst_cnt_q < MaxBursts) ? StAlarm : StSilent;
                end else begin
                    phase_d = phase_q + PhaseW'(1);
                end
            end
            StSilent: begin
                state_d = StSilent;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every fresh burst starts with the tone on and counts itself.
        if ((state_d == StAlarm) && (state_q != StAlarm)) begin
            buzzer_d = 1'b1;
            phase_d  = '0;
            if (burst_cnt_q < MaxBursts) begin
                burst_cnt_d = burst_cnt_q + 3'd1;
            end
        end
        if (state_d != StAlarm) begin
            buzzer_d = 1'b0;
        end

        warn_led_d     = (state_d == StWarn);
        alarm_active_d = (state_d == StAlarm) || (state_d == StPause);
    end

    // State and registered outputs; reset clears everything without waiting for a tick.
    always_ff @(posedge OSClk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            phase_q        <= '0;
            warn_led_q     <= 1'b0;
            buzzer_q       <= 1'b0;
            alarm_active_q <= 1'b0;
            burst_cnt_q    <= 3'd0;
            bcd_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            warn_led_q     <= warn_led_d;
            buzzer_q       <= buzzer_d;
            alarm_active_q <= alarm_active_d;
            burst_cnt_q    <= burst_cnt_d;
            bcd_err_q      <= bcd_err_d;
        end
    end

    assign bus.warn_led     = warn_led_q;
    assign bus.buzzer       = buzzer_q;
    assign bus.alarm_active = alarm_active_q;
    assign bus.burst_cnt    = burst_cnt_q;
    assign bus.bcd_err      = bcd_err_q;

endmodule
